// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32 control sequencer.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    IC_NONE, IC_R, IC_I, IC_LW, IC_SW, IC_BR
  } iclass_e;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_ILL  = 2'b01;
  localparam logic [1:0] CAUSE_TMO  = 2'b10;

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational decode of opcode/funct3/funct7[5] into instruction class,
// ALU operation, immediate format, operand-B select and a legality flag.
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output iclass_e    iclass,
  output logic [3:0] operation,
  output logic [1:0] imm_src,
  output logic       alu_src,
  output logic       legal
);

  logic       is_r;
  logic       f_legal;
  logic [3:0] f_op;

  assign is_r = (opcode == OP_R);

  // funct3 map shared by R and I forms; funct7[5] only selects SUB (R) and SRA.
  always_comb begin
    f_legal = 1'b1;
    f_op    = ALU_ADD;
    case (funct3)
      3'b000: f_op = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001: begin f_op = ALU_SLL; f_legal = !funct7_5; end
      3'b010: f_op = ALU_SLT;
      3'b100: f_op = ALU_XOR;
      3'b101: f_op = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110: f_op = ALU_OR;
      3'b111: f_op = ALU_AND;
      default: f_legal = 1'b0;
    endcase
    if (is_r && funct7_5 && !(funct3 == 3'b000 || funct3 == 3'b101))
      f_legal = 1'b0;
  end

  always_comb begin
    iclass    = IC_NONE;
    operation = ALU_ADD;
    imm_src   = IMM_I;
    alu_src   = 1'b0;
    legal     = 1'b0;
    case (opcode)
      OP_R:  begin iclass = IC_R;  operation = f_op; alu_src = 1'b1; legal = f_legal; end
      OP_I:  begin iclass = IC_I;  operation = f_op; legal = f_legal; end
      OP_LW: begin iclass = IC_LW; legal = (funct3 == 3'b010); end
      OP_SW: begin iclass = IC_SW; imm_src = IMM_S; legal = (funct3 == 3'b010); end
      OP_BR: begin
        iclass    = IC_BR;
        operation = ALU_SUB;
        imm_src   = IMM_B;
        alu_src   = 1'b1;
        legal     = (funct3[2:1] == 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH..WB per instruction, memory wait with
// timeout, sticky trap and retired-instruction counter.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [31:0]      instruction,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             pc_src,
  output logic             alu_src,
  output logic [1:0]       imm_src,
  output logic [3:0]       operation,
  output logic             rg_wrt_en,
  output logic             mem_we,
  output logic             mem_re,
  output logic             mem_to_reg,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam int               TMO_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  iclass_e    dec_class;
  logic [3:0] dec_op;
  logic [1:0] dec_imm;
  logic       dec_alu_src;
  logic       dec_legal;
  logic       unused_ir;

  assign unused_ir = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

  mc_alu_decode u_dec (
    .opcode    (ir_q[6:0]),
    .funct3    (ir_q[14:12]),
    .funct7_5  (ir_q[30]),
    .iclass    (dec_class),
    .operation (dec_op),
    .imm_src   (dec_imm),
    .alu_src   (dec_alu_src),
    .legal     (dec_legal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      tmo_q     <= '0;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      tmo_q     <= tmo_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    tmo_d      = '0;
    cause_d    = cause_q;
    instret_d  = instret_q;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    imm_src    = IMM_I;
    operation  = '0;
    rg_wrt_en  = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_to_reg = 1'b0;

    // Datapath controls are held from DECODE through retirement.
    if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      alu_src   = dec_alu_src;
      imm_src   = dec_imm;
      operation = dec_op;
    end

    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  begin ir_d = instruction; state_d = S_DECODE; end
      S_DECODE: begin
        if (!dec_legal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (dec_class)
          IC_LW, IC_SW: state_d = S_MEM;
          IC_BR: begin
            pc_we   = 1'b1;
            pc_src  = ir_q[12] ? !zero : zero;
            state_d = run ? S_FETCH : S_IDLE;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_re = (dec_class == IC_LW);
        mem_we = (dec_class == IC_SW);
        if (mem_ready) begin
          if (dec_class == IC_SW) begin
            pc_we   = 1'b1;
            state_d = run ? S_FETCH : S_IDLE;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TMO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_WB: begin
        rg_wrt_en  = 1'b1;
        mem_to_reg = (dec_class == IC_LW);
        pc_we      = 1'b1;
        state_d    = run ? S_FETCH : S_IDLE;
      end
      S_TRAP: ;
      default: state_d = S_IDLE;
    endcase

    if (pc_we) instret_d = instret_q + CNT_W'(1);
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_TRAP);
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed + randomized bench for mc_ctrl_fsm against a table-driven reference.
module tb_mc_ctrl_fsm;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 4;

  localparam logic [6:0] T_R = 7'b0110011, T_I = 7'b0010011, T_LW = 7'b0000011;
  localparam logic [6:0] T_SW = 7'b0100011, T_BR = 7'b1100011;
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_NONE = 5;

  // ALU code by {funct7[5], funct3}; -1 means illegal.
  localparam int R_TAB [16] = '{2, 4, 7, -1, 3, 5, 1, 0, 6, -1, -1, -1, -1, 8, -1, -1};
  localparam int I_TAB [16] = '{2, 4, 7, -1, 3, 5, 1, 0, 2, -1, 7, -1, 3, 8, 1, 0};

  logic             clk = 1'b0;
  logic             reset, run, zero, mem_ready;
  logic [31:0]      instruction;
  logic             pc_we, pc_src, alu_src, rg_wrt_en, mem_we, mem_re, mem_to_reg, busy, trap;
  logic [1:0]       imm_src, trap_cause;
  logic [3:0]       operation;
  logic [CNT_W-1:0] instret;
  logic [20:0]      outs;

  int nvec = 0, nerr = 0, exp_ret = 0;

  assign outs = {pc_we, pc_src, alu_src, imm_src, operation, rg_wrt_en, mem_we, mem_re,
                 mem_to_reg, busy, trap, trap_cause, instret};

  mc_ctrl_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run), .instruction(instruction), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .pc_src(pc_src), .alu_src(alu_src),
    .imm_src(imm_src), .operation(operation), .rg_wrt_en(rg_wrt_en), .mem_we(mem_we),
    .mem_re(mem_re), .mem_to_reg(mem_to_reg), .busy(busy), .trap(trap),
    .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: class, legality, ALU code, operand select, immediate format,
  // cycle of retirement/trap (counted from FETCH = 1), trap cause, MEM cycles.
  function automatic void ref_model(input logic [31:0] ins, input int wt,
      output int kind, output int op, output int asrc, output int imm,
      output int lat, output int tcause, output int mcyc);
    logic [6:0] opc;
    logic [3:0] key;
    bit legal;
    opc = ins[6:0];
    key = {ins[30], ins[14:12]};
    kind = K_NONE; op = 2; asrc = 0; imm = 0; legal = 0; mcyc = 0; tcause = 0;
    case (opc)
      T_R:  begin kind = K_R;  op = R_TAB[key]; asrc = 1; legal = (op >= 0); end
      T_I:  begin kind = K_I;  op = I_TAB[key]; legal = (op >= 0); end
      T_LW: begin kind = K_LW; legal = (ins[14:12] == 3'd2); end
      T_SW: begin kind = K_SW; imm = 1; legal = (ins[14:12] == 3'd2); end
      T_BR: begin kind = K_BR; op = 6; asrc = 1; imm = 2; legal = (ins[14:12] <= 3'd1); end
      default: ;
    endcase
    if (!legal) begin lat = 3; tcause = 1; end
    else if (kind == K_BR) lat = 3;
    else if (kind == K_R || kind == K_I) lat = 4;
    else if (wt >= MEM_TIMEOUT) begin lat = 4 + MEM_TIMEOUT; tcause = 2; mcyc = MEM_TIMEOUT; end
    else begin mcyc = wt + 1; lat = (kind == K_LW ? 5 : 4) + wt; end
  endfunction

  // Runs one instruction from IDLE or FETCH; entered and left at posedge+1.
  task automatic do_instr(input logic [31:0] ins, input bit z, input int wt,
                          input bit run_after, output bit trapped);
    int kind, op, asrc, imm, lat, tcause, mcyc;
    int cyc = 0, mcnt = 0, nre = 0, nwe = 0, nrg = 0, npc = 0, nconf = 0, end_cyc = 0;
    bit done = 0, tseen = 0;
    logic r_src = 0, r_asrc = 0, r_m2r = 0;
    logic [1:0] r_imm = 0;
    logic [3:0] r_op = 0;
    ref_model(ins, wt, kind, op, asrc, imm, lat, tcause, mcyc);
    instruction = ins;
    zero = z;
    if (!busy) begin run = 1'b1; @(posedge clk); #1; end
    while (!done && cyc < 40) begin
      cyc++;
      if (mem_re || mem_we) begin mem_ready = (mcnt == wt); mcnt++; end
      else mem_ready = 1'($urandom);
      #1;
      run = pc_we ? run_after : 1'($urandom);
      @(negedge clk);
      if (mem_re) nre++;
      if (mem_we) nwe++;
      if (rg_wrt_en) begin nrg++; r_m2r = mem_to_reg; end
      if (rg_wrt_en && mem_we) nconf++;
      if (pc_we) begin
        npc++; r_src = pc_src; r_op = operation; r_asrc = alu_src; r_imm = imm_src;
        done = 1; end_cyc = cyc;
      end
      if (trap) begin tseen = 1; done = 1; end_cyc = cyc; end
      @(posedge clk); #1;
    end
    chk("bounded_wait", done, 1);
    chk("end_cycle", end_cyc, lat);
    chk("pc_we_count", npc, (tcause == 0) ? 1 : 0);
    chk("trap_seen", tseen, tcause != 0);
    chk("mem_re_cycles", nre, (kind == K_LW) ? mcyc : 0);
    chk("mem_we_cycles", nwe, (kind == K_SW) ? mcyc : 0);
    chk("rg_wrt_cycles", nrg, (tcause == 0 && kind inside {K_R, K_I, K_LW}) ? 1 : 0);
    chk("rg_and_mem_we", nconf, 0);
    if (tcause == 0) begin
      exp_ret++;
      chk("pc_src", r_src, (kind == K_BR) ? (ins[12] ? !z : z) : 1'b0);
      chk("operation", r_op, op);
      chk("alu_src", r_asrc, asrc);
      if (kind != K_R) chk("imm_src", r_imm, imm);
      if (kind != K_BR && kind != K_SW) chk("mem_to_reg", r_m2r, kind == K_LW);
      chk("busy_after_retire", busy, run_after);
      chk("instret", instret, exp_ret % (1 << CNT_W));
    end else begin
      chk("trap_cause", trap_cause, tcause);
      chk("busy_in_trap", busy, 0);
    end
    trapped = (tcause != 0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    run = 1'b0;
    #1 chk("reset_outputs", outs, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    exp_ret = 0;
  endtask

  initial begin
    logic [31:0] ins;
    bit tr;
    int npc;
    reset = 1'b0; run = 1'b0; zero = 1'b0; mem_ready = 1'b0; instruction = '0;
    #3 chk("reset_state", outs, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    do_instr(32'h002081B3, 1'b0, 0, 1'b1, tr);   // ADD x3,x1,x2
    do_instr(32'h0080A283, 1'b0, 3, 1'b0, tr);   // LW x5,8(x1), 3 wait cycles
    do_instr(32'h00000063, 1'b1, 0, 1'b1, tr);   // BEQ, taken
    do_instr(32'h00001063, 1'b1, 0, 1'b0, tr);   // BNE, not taken
    do_instr(32'h0080A283, 1'b0, 15, 1'b0, tr);  // ready on the last allowed cycle
    do_instr(32'h0020A423, 1'b0, 0, 1'b1, tr);   // SW zero wait
    do_instr(32'h002081B3, 1'b0, 0, 1'b0, tr);   // run low at retire -> IDLE

    do_instr(32'h0000007F, 1'b0, 0, 1'b0, tr);   // illegal opcode
    npc = 0;
    repeat (5) begin run = 1'b1; @(negedge clk); if (pc_we) npc++; end
    chk("trap_no_pc_we", npc, 0);
    chk("trap_sticky", {trap, trap_cause}, 3'b101);
    @(posedge clk); #1;
    do_reset();
    chk("trap_cleared", trap, 0);

    do_instr(32'h0020A423, 1'b0, 1000, 1'b0, tr); // SW, ready never arrives
    do_reset();

    for (int i = 0; i < 60; i++) begin
      ins = $urandom;
      case ($urandom_range(0, 9))
        0, 1: begin ins[6:0] = T_R; ins[30] = ($urandom_range(0, 3) == 0); end
        2, 3: ins[6:0] = T_I;
        4, 5: begin ins[6:0] = T_LW; if ($urandom_range(0, 3) != 0) ins[14:12] = 3'd2; end
        6:    begin ins[6:0] = T_SW; if ($urandom_range(0, 3) != 0) ins[14:12] = 3'd2; end
        7, 8: begin ins[6:0] = T_BR; if ($urandom_range(0, 3) != 0) ins[14:13] = 2'b00; end
        default: ;
      endcase
      do_instr(ins, 1'($urandom), ($urandom_range(0, 11) == 0) ? 16 + $urandom_range(0, 3)
               : $urandom_range(0, 4), 1'($urandom), tr);
      if (tr) do_reset();
    end

    do_reset();
    for (int i = 0; i < 20; i++)                 // instret wraps past 2**CNT_W-1
      do_instr(32'h40208133, 1'b0, 0, i != 19, tr);

    instruction = 32'h0020A423;                  // reset lands mid-MEM
    mem_ready = 1'b0;
    run = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("mid_mem_we", {mem_we, busy}, 2'b11);
    do_reset();
    chk("idle_after_reset", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
